// File: rtl/mesi_bus_pkg.sv
// Shared types and constants for the MESI bus controller and its helpers.
// Bus FSM states, line-state encoding and bus-op polarity live here.
package mesi_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        SNOOP = 3'd2,
        OWNWB = 3'd3,
        MEM   = 3'd4,
        RESP  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        INVALID   = 2'b00,
        SHARED    = 2'b01,
        EXCLUSIVE = 2'b10,
        MODIFIED  = 2'b11
    } mesi_t;

    localparam logic BUS_RD = 1'b1;
    localparam logic BUS_WR = 1'b0;

    // A single cache still needs a one-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (wrapping) wins; returns a one-hot grant and the winner's index.
module rr_arbiter
    import mesi_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester is the last write.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mesi_bus_controller.sv
// Shared-bus responder for the MESI caches: serves write-backs, arbitrates misses,
// broadcasts them for snooping and returns the fill word with a one-cycle pulse.
module mesi_bus_controller
    import mesi_bus_pkg::*;
#(
    parameter int NUM_PROC  = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int MEM_LAT   = 3,
    localparam int ID_W     = id_width(NUM_PROC)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PROC-1:0]        rd_ms,
    input  logic [NUM_PROC-1:0]        wr_ms,
    input  logic [NUM_PROC-1:0]        wr_bk,
    input  logic [NUM_PROC*ADDR_W-1:0] req_addr,
    input  logic [NUM_PROC*DATA_W-1:0] req_data,
    input  logic [NUM_PROC-1:0]        snoop_shared,
    output logic                       bus_valid,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic                       bus_rdwr,
    output logic [ID_W-1:0]            bus_proc_id,
    output logic [NUM_PROC-1:0]        fill_ready,
    output logic [DATA_W-1:0]          fill_data,
    output logic                       shared_out,
    output logic                       busy
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    // Handshake: rd_ms/wr_ms are levels held with a stable address until the
    // one-cycle fill_ready pulse for that cache; wr_bk is sampled in IDLE and SNOOP.
    state_t              state, state_next;
    logic [ID_W-1:0]     rr_ptr, req_id, arb_idx, wb_sel, own_sel;
    logic [NUM_PROC-1:0] arb_grant, req_onehot, owner_vec;
    logic [CNT_W-1:0]    lat_cnt;
    logic [ADDR_W-1:0]   lat_addr;
    logic [IDX_W-1:0]    lat_idx;
    logic [DATA_W-1:0]   hold_data, fill_word;
    logic                lat_rdwr, shared_q, mem_done;
    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    assign lat_idx    = lat_addr[IDX_W+1:2];
    assign req_onehot = NUM_PROC'(1) << req_id;
    assign owner_vec  = wr_bk & ~req_onehot;
    assign mem_done   = (lat_cnt == CNT_W'(MEM_LAT - 1));

    rr_arbiter #(.N(NUM_PROC), .IW(ID_W)) u_arb (
        .req   (rd_ms | wr_ms),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // Lowest-index write-back source and lowest-index snooped owner.
    always_comb begin
        wb_sel  = '0;
        own_sel = '0;
        for (int i = NUM_PROC - 1; i >= 0; i--) begin
            if (wr_bk[i])     wb_sel  = ID_W'(i);
            if (owner_vec[i]) own_sel = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|wr_bk)          state_next = WB;
                else if (|arb_grant) state_next = SNOOP;
            end
            WB:    state_next = IDLE;
            SNOOP: begin
                if (|owner_vec)              state_next = OWNWB;
                else if (lat_rdwr == BUS_RD) state_next = MEM;
                else                         state_next = RESP;
            end
            OWNWB: state_next = RESP;
            MEM:   if (mem_done) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus_valid   = 1'b0;
        bus_addr    = '0;
        bus_rdwr    = 1'b0;
        bus_proc_id = '0;
        fill_ready  = '0;
        fill_data   = '0;
        shared_out  = 1'b0;
        busy        = (state != IDLE);
        case (state)
            SNOOP: begin
                bus_valid   = 1'b1;
                bus_addr    = lat_addr;
                bus_rdwr    = lat_rdwr;
                bus_proc_id = req_id;
            end
            RESP: begin
                fill_ready = req_onehot;
                fill_data  = fill_word;
                shared_out = shared_q;
            end
            default: ;
        endcase
    end

    // Transaction context; lat_addr/hold_data double as the write-back address/data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr    <= '0;
            lat_cnt   <= '0;
            req_id    <= '0;
            lat_addr  <= '0;
            lat_rdwr  <= BUS_WR;
            hold_data <= '0;
            shared_q  <= 1'b0;
        end else begin
            lat_cnt <= '0;
            case (state)
                IDLE: begin
                    if (|wr_bk) begin
                        lat_addr  <= req_addr[wb_sel*ADDR_W +: ADDR_W];
                        hold_data <= req_data[wb_sel*DATA_W +: DATA_W];
                    end else if (|arb_grant) begin
                        req_id   <= arb_idx;
                        lat_addr <= req_addr[arb_idx*ADDR_W +: ADDR_W];
                        lat_rdwr <= (|(arb_grant & rd_ms)) ? BUS_RD : BUS_WR;
                    end
                end
                SNOOP: begin
                    shared_q  <= (lat_rdwr == BUS_RD) && (|(snoop_shared & ~req_onehot));
                    hold_data <= req_data[own_sel*DATA_W +: DATA_W];
                end
                OWNWB: shared_q <= (lat_rdwr == BUS_RD);
                MEM:   lat_cnt <= lat_cnt + 1'b1;
                RESP:  rr_ptr <= (req_id == ID_W'(NUM_PROC - 1)) ? '0 : req_id + 1'b1;
                default: ;
            endcase
        end
    end

    // Memory survives reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == WB || state == OWNWB) mem[lat_idx] <= hold_data;
        end
        if (state == SNOOP || state == MEM) fill_word <= mem[lat_idx];
        else if (state == OWNWB)            fill_word <= hold_data;
    end

endmodule

// File: tb/tb_mesi_bus_controller.sv
// Self-checking bench for mesi_bus_controller: fills are compared against a
// queue of {fill_ready, shared_out, fill_data} pushed when each request is driven.
module tb_mesi_bus_controller;

    localparam int NP  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int EW  = NP + 1 + DW;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NP-1:0]     rd_ms, wr_ms, wr_bk, snoop_shared;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_data;
    logic              bus_valid, bus_rdwr, shared_out, busy;
    logic [AW-1:0]     bus_addr;
    logic [1:0]        bus_proc_id;
    logic [NP-1:0]     fill_ready;
    logic [DW-1:0]     fill_data;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] model_mem[int];

    mesi_bus_controller #(
        .NUM_PROC(NP), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1024), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .rd_ms(rd_ms), .wr_ms(wr_ms), .wr_bk(wr_bk),
        .req_addr(req_addr), .req_data(req_data), .snoop_shared(snoop_shared),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_rdwr(bus_rdwr),
        .bus_proc_id(bus_proc_id), .fill_ready(fill_ready), .fill_data(fill_data),
        .shared_out(shared_out), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[p*AW +: AW] = a;
        req_data[p*DW +: DW] = d;
    endtask

    task automatic do_wb(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_req(p, a, d);
        model_mem[int'(a[11:2])] = d;
        wr_bk[p] = 1'b1;
        tick();
        wr_bk[p] = 1'b0;
        tick();
    endtask

    task automatic wait_fill(input int start, output int cyc);
        cyc = start;
        while (fill_ready === '0 && cyc < start + 40) begin
            tick();
            cyc++;
        end
    endtask

    function automatic logic [EW-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    // scenarios
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus_valid, bus_addr, bus_rdwr, bus_proc_id, fill_ready, fill_data, shared_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b addr=%h rdwr=%b id=%0d ready=%b data=%h shared=%b exp all 0",
                     bus_valid, bus_addr, bus_rdwr, bus_proc_id, fill_ready, fill_data, shared_out);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        int cyc;
        logic [EW-1:0] got, exp;
        do_wb(1, 32'h100, 32'h1000_0100);
        do_wb(1, 32'h200, 32'h2000_0200);
        do_wb(1, 32'h300, 32'h3000_0300);
        exp_q.push_back({4'b0001, 1'b0, 32'h1000_0100});
        exp_q.push_back({4'b0100, 1'b0, 32'h2000_0200});
        exp_q.push_back({4'b0001, 1'b0, 32'h3000_0300});
        set_req(0, 32'h100, '0);
        set_req(2, 32'h200, '0);
        rd_ms = 4'b0101;
        tick();
        checks++;
        if (bus_valid !== 1'b1 || bus_proc_id !== 2'd0) begin
            errors++; $display("FAIL rr_first_grant: got valid=%b id=%0d exp valid=1 id=0", bus_valid, bus_proc_id);
        end
        wait_fill(1, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rr_fill0: got %h exp %h", got, exp); end
        // cache0 immediately issues a new miss, so 0 and 2 compete with the pointer at 1
        set_req(0, 32'h300, '0);
        tick();
        wait_fill(0, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rr_fill2: got %h exp %h", got, exp); end
        rd_ms[2] = 1'b0;
        tick();
        wait_fill(0, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rr_fill0_again: got %h exp %h", got, exp); end
        rd_ms = '0;
        tick();
    endtask

    task automatic test_read_no_owner();
        int cyc;
        logic [EW-1:0] got, exp;
        do_wb(2, 32'h40, 32'hDEAD_BEEF);
        set_req(1, 32'h40, '0);
        exp_q.push_back({4'b0010, 1'b0, 32'hDEAD_BEEF});
        rd_ms[1] = 1'b1;
        tick();
        checks++;
        if ({bus_valid, bus_proc_id, bus_rdwr, bus_addr} !== {1'b1, 2'd1, 1'b1, 32'h40}) begin
            errors++; $display("FAIL rd_broadcast: got valid=%b id=%0d rdwr=%b addr=%h exp 1/1/1/40",
                               bus_valid, bus_proc_id, bus_rdwr, bus_addr);
        end
        tick();
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL rd_bus_one_cycle: got %b exp 0", bus_valid); end
        wait_fill(2, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rd_fill: got %h exp %h", got, exp); end
        checks++;
        if (cyc !== LAT + 2) begin errors++; $display("FAIL rd_latency: got %0d exp %0d", cyc, LAT + 2); end
        rd_ms = '0;
        tick();
        checks++;
        if (fill_ready !== '0 || fill_data !== '0) begin
            errors++; $display("FAIL rd_pulse_end: got ready=%b data=%h exp 0/0", fill_ready, fill_data);
        end
    endtask

    task automatic test_shared();
        int cyc;
        logic [EW-1:0] got, exp;
        do_wb(0, 32'h80, 32'h8080_8080);
        set_req(3, 32'h80, '0);
        snoop_shared = 4'b0001;
        exp_q.push_back({4'b1000, 1'b1, 32'h8080_8080});
        rd_ms[3] = 1'b1;
        tick();
        wait_fill(1, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL shared_other: got %h exp %h", got, exp); end
        rd_ms = '0;
        tick();
        snoop_shared = 4'b1000;
        exp_q.push_back({4'b1000, 1'b0, 32'h8080_8080});
        rd_ms[3] = 1'b1;
        tick();
        wait_fill(1, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL shared_self_ignored: got %h exp %h", got, exp); end
        rd_ms = '0;
        snoop_shared = '0;
        tick();
    endtask

    task automatic test_owner();
        int cyc;
        logic [EW-1:0] got, exp;
        do_wb(0, 32'h10, 32'h1111_1111);
        set_req(1, 32'h10, '0);
        exp_q.push_back({4'b0010, 1'b1, 32'h1234_5678});
        rd_ms[1] = 1'b1;
        tick();
        set_req(2, 32'h10, 32'h1234_5678);
        wr_bk[2] = 1'b1;
        tick();
        wr_bk[2] = 1'b0;
        model_mem[4] = 32'h1234_5678;
        wait_fill(2, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL owner_fill: got %h exp %h", got, exp); end
        checks++;
        if (cyc !== 3) begin errors++; $display("FAIL owner_latency: got %0d exp 3", cyc); end
        rd_ms = '0;
        tick();
        set_req(0, 32'h10, '0);
        exp_q.push_back({4'b0001, 1'b0, 32'h1234_5678});
        rd_ms[0] = 1'b1;
        tick();
        wait_fill(1, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL owner_mem_written: got %h exp %h", got, exp); end
        rd_ms = '0;
        tick();
    endtask

    task automatic test_write_miss();
        int cyc;
        logic [EW-1:0] got, exp;
        do_wb(3, 32'h20, 32'hCAFE_F00D);
        set_req(0, 32'h20, '0);
        snoop_shared = 4'b0010;
        exp_q.push_back({4'b0001, 1'b0, 32'hCAFE_F00D});
        wr_ms[0] = 1'b1;
        tick();
        checks++;
        if ({bus_valid, bus_proc_id, bus_rdwr, bus_addr} !== {1'b1, 2'd0, 1'b0, 32'h20}) begin
            errors++; $display("FAIL wr_broadcast: got valid=%b id=%0d rdwr=%b addr=%h exp 1/0/0/20",
                               bus_valid, bus_proc_id, bus_rdwr, bus_addr);
        end
        wait_fill(1, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL wr_fill: got %h exp %h", got, exp); end
        checks++;
        if (cyc !== 2) begin errors++; $display("FAIL wr_latency: got %0d exp 2", cyc); end
        wr_ms = '0;
        snoop_shared = '0;
        tick();
        set_req(2, 32'h20, '0);
        exp_q.push_back({4'b0100, 1'b0, 32'hCAFE_F00D});
        rd_ms[2] = 1'b1;
        wr_ms[2] = 1'b1;
        tick();
        checks++;
        if (bus_rdwr !== 1'b1) begin errors++; $display("FAIL rdwr_both_is_read: got %b exp 1", bus_rdwr); end
        wait_fill(1, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp || cyc !== LAT + 2) begin
            errors++; $display("FAIL rdwr_both_fill: got %h at %0d exp %h at %0d", got, cyc, exp, LAT + 2);
        end
        rd_ms = '0;
        wr_ms = '0;
        tick();
    endtask

    task automatic test_wb_priority();
        int cyc;
        logic [EW-1:0] got, exp;
        do_wb(1, 32'h24, 32'h0000_005A);
        set_req(0, 32'h24, '0);
        set_req(2, 32'h24, 32'h0000_00A5);
        exp_q.push_back({4'b0001, 1'b0, 32'h0000_00A5});
        rd_ms[0] = 1'b1;
        wr_bk[2] = 1'b1;
        tick();
        wr_bk[2] = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus_valid !== 1'b0) begin
            errors++; $display("FAIL wb_first: got busy=%b valid=%b exp 1/0", busy, bus_valid);
        end
        wait_fill(1, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp) begin errors++; $display("FAIL wb_before_miss: got %h exp %h", got, exp); end
        checks++;
        if (cyc !== LAT + 4) begin errors++; $display("FAIL wb_miss_latency: got %0d exp %0d", cyc, LAT + 4); end
        rd_ms = '0;
        tick();
    endtask

    task automatic test_reset_midflight();
        int cyc;
        logic [EW-1:0] got, exp;
        do_wb(0, 32'h30, 32'h0BAD_CAFE);
        set_req(3, 32'h30, '0);
        rd_ms[3] = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({bus_valid, bus_addr, bus_rdwr, bus_proc_id, fill_ready, fill_data, shared_out, busy} !== '0) begin
            errors++; $display("FAIL midreset_outputs: got valid=%b ready=%b data=%h busy=%b exp all 0",
                               bus_valid, fill_ready, fill_data, busy);
        end
        tick();
        checks++;
        if (fill_ready !== '0) begin errors++; $display("FAIL midreset_no_fill: got %b exp 0", fill_ready); end
        reset = 1'b1;
        exp_q.push_back({4'b1000, 1'b0, 32'h0BAD_CAFE});
        wait_fill(0, cyc);
        got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
        checks++;
        if (got !== exp || cyc !== LAT + 2) begin
            errors++; $display("FAIL midreset_reserve: got %h at %0d exp %h at %0d", got, cyc, exp, LAT + 2);
        end
        rd_ms = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, p, op, exp_lat;
        logic [AW-1:0] a;
        logic [NP-1:0] sn, others;
        logic sh;
        logic [EW-1:0] got, exp;
        for (int i = 0; i < 4; i++) do_wb(i, AW'(32'h400 + 4 * i), DW'($urandom));
        for (int n = 0; n < 10; n++) begin
            p  = $urandom_range(0, NP - 1);
            a  = AW'(32'h400 + 4 * $urandom_range(0, 3));
            op = $urandom_range(0, 2);
            sn = NP'($urandom_range(0, 15));
            others = sn & ~(NP'(1) << p);
            sh = (op != 1) && (|others);
            exp_lat = (op == 1) ? 2 : LAT + 2;
            set_req(p, a, '0);
            snoop_shared = sn;
            exp_q.push_back({NP'(1) << p, sh, model_mem[int'(a[11:2])]});
            rd_ms[p] = (op != 1);
            wr_ms[p] = (op != 0);
            tick();
            wait_fill(1, cyc);
            got = {fill_ready, shared_out, fill_data}; exp = pop_exp();
            checks++;
            if (got !== exp || cyc !== exp_lat) begin
                errors++; $display("FAIL b2b_%0d: got %h at %0d exp %h at %0d", n, got, cyc, exp, exp_lat);
            end
            rd_ms = '0;
            wr_ms = '0;
            tick();
        end
        snoop_shared = '0;
    endtask

    initial begin
        rd_ms = '0;
        wr_ms = '0;
        wr_bk = '0;
        snoop_shared = '0;
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_round_robin();
        test_read_no_owner();
        test_shared();
        test_owner();
        test_write_miss();
        test_wb_priority();
        test_reset_midflight();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries exp 0", exp_q.size()); end
        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mesi_bus_controller.md
Name: mesi_bus_controller

Overview:
- Shared-bus responder for the MESI private caches.
- Accepts the caches' miss and write-back requests, arbitrates round-robin, and broadcasts each winning transaction for snooping.
- Collects shared and modified-owner responses, services fills from a word-addressed main-memory array, and returns fill data with a one-cycle ready pulse.
- Sits between the NUM_PROC cache instances and main memory; it is the only bus master.

Parameters:
NUM_PROC, 4, number of caches / processor IDs (ID width = clog2(NUM_PROC))
ADDR_W, 32, address width
DATA_W, 32, data word width
MEM_DEPTH, 1024, main-memory words; index = addr[clog2(MEM_DEPTH)+1:2], upper bits ignored (wrap)
MEM_LAT, 3, cycles from start of MEM state to fill response (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-low
rd_ms  in  NUM_PROC  per-cache read-miss request, level, held until fill_ready
wr_ms  in  NUM_PROC  per-cache write-miss request, level, held until fill_ready
wr_bk  in  NUM_PROC  per-cache write-back (modified victim or snooped M owner)
req_addr  in  NUM_PROC*ADDR_W  per-cache request/write-back address, slice i = cache i
req_data  in  NUM_PROC*DATA_W  per-cache write-back data
snoop_shared  in  NUM_PROC  per-cache "line present" response during SNOOP
bus_valid  out  1  snoop broadcast valid
bus_addr  out  ADDR_W  broadcast address
bus_rdwr  out  1  1 = read, 0 = write (invalidate)
bus_proc_id  out  clog2(NUM_PROC)  requester ID of the broadcast
fill_ready  out  NUM_PROC  one-hot, one-cycle completion to requester
fill_data  out  DATA_W  fill word, valid with fill_ready
shared_out  out  1  another cache holds the line, valid with fill_ready
busy  out  1  FSM not IDLE

Behaviour:
- Reset (reset==0 at posedge):
  - FSM to IDLE, RR pointer to 0, MEM_LAT counter cleared.
  - All outputs 0; busy 0.
  - Memory contents unaffected.
  - An in-flight transaction is dropped with no fill_ready; the requester keeps its level request and is re-arbitrated.
- States: IDLE, WB, SNOOP, OWNWB, MEM, RESP.
- IDLE:
  - Any wr_bk set: go to WB. Serve the lowest index with wr_bk set; write-backs have priority over misses.
  - Else any rd_ms|wr_ms set: grant by round-robin starting at the RR pointer, latch the winner's ID/address/type, go to SNOOP.
  - A cache with both rd_ms and wr_ms set is treated as a read.
- WB: mem[idx(req_addr[i])] <= req_data[i]; 1 cycle; return to IDLE.
- SNOOP: exactly 1 cycle, bus_valid=1 with the latched addr/rdwr/id.
  - shared = OR of snoop_shared over all caches except the requester, registered.
  - If a non-requester asserts wr_bk in this cycle (M owner), latch its data and go to OWNWB.
  - Else a read goes to MEM; a write goes to RESP.
- OWNWB: 1 cycle.
  - Write the owner's data to memory; use it as fill_data and bypass memory latency.
  - Go to RESP. shared forced 1 for reads (owner drops to SHARED); 0 for writes.
- MEM: wait MEM_LAT cycles, read mem[idx(addr)], go to RESP.
- RESP: 1 cycle.
  - fill_ready[requester]=1, fill_data, shared_out driven.
  - For a write miss: fill_data = memory word (read before completion, MEM skipped, value informational) and shared_out=0.
  - RR pointer <= requester+1 mod NUM_PROC. Return to IDLE.
- Outside RESP, fill_ready=0 and fill_data/shared_out hold 0. Outside SNOOP, bus_valid=0 and bus_addr/rdwr/id are 0.
- Latency, read miss with no owner: request seen in IDLE at cycle N, fill_ready at N+2+MEM_LAT.
- Latency, with owner: N+3.
- Latency, write miss: N+2.
- Requests deasserted before grant are ignored. Requests are sampled only in IDLE; the requester must hold the address stable until fill_ready.
- Write-back and miss from the same cache in the same IDLE cycle: the write-back is served first, then the miss.

Decomposition:
- Package mesi_bus_pkg:
  - state enum (IDLE..RESP).
  - MESI state encoding (INVALID=00, SHARED=01, EXCLUSIVE=10, MODIFIED=11).
  - Bus op constants BUS_RD=1, BUS_WR=0.
  - clog2-derived ID width.
- Sub-module rr_arbiter: NUM_PROC requests + pointer in, one-hot grant + index out, combinational.

Test Plan:
- mem[0x40>>2]=0xDEADBEEF, cache1 rd_ms @0x40, no snoop_shared -> bus_valid 1 cycle with id=1, rdwr=1; fill_ready=0010 exactly MEM_LAT+2 cycles later, fill_data=0xDEADBEEF, shared_out=0.
- cache0 and cache2 rd_ms same cycle, pointer=0 -> cache0 served first, then cache2; next simultaneous 0/2 request -> cache2 wins after pointer moved to 1.
- cache3 rd_ms @0x80, cache0 snoop_shared=1 -> shared_out=1 with fill_ready=1000; cache3's own snoop_shared=1 alone -> shared_out=0.
- cache1 rd_ms @0x10, cache2 asserts wr_bk with 0x12345678 during SNOOP -> fill_ready at N+3, fill_data=0x12345678, shared_out=1, mem[4]=0x12345678.
- cache0 wr_ms @0x20 -> bus_rdwr=0 broadcast, fill_ready=0001 at N+2, shared_out=0; wr_bk from cache2 @0x24 data 0xA5 pending alongside a miss -> mem[9]=0xA5 before the miss's SNOOP.
- reset=0 during MEM -> next cycle all outputs 0, busy 0, no fill_ready; after reset=1, held request re-served correctly.
